id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline stage of the five-stage RISC-V core. It registers the decoded instruction (operands, immediate, register indices, ALU and memory control) into the EX stage that feeds ALU control and the ALU. It detects load-use hazards against the instruction currently in EX and inserts bubbles. It honours branch flushes and downstream stalls, and keeps a saturating count of inserted load-use bubbles.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of bubble counter

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded datapath fields
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads that source
- id_alu_op  in  2  00 add, 01 sub/branch, 10 R-type
- id_bit_30  in  1  instr[30]
- id_funct3  in  3  instr[14:12]
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each  control
- ex_flush  in  1  taken branch resolved in EX; kill ID instruction
- ext_stall  in  1  downstream (MEM) stall; freeze stage
- ex_valid  out  1  EX holds a real instruction
- ex_* (one per id_* field above, same width)  out  registered copies
- load_use_stall  out  1  combinational; IF and IF/ID hold when high
- bubble_count  out  CNT_W  load-use bubbles inserted, saturating

## Operation
- hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- load_use_stall = hazard & ~ex_flush & ~ext_stall.
- Per-edge priority, first match wins:
  1. rst: all ex_* and ex_valid = 0; bubble_count = 0.
  2. ext_stall: every register holds. ex_flush is ignored, because the EX branch stays in place and reasserts flush after the stall.
  3. ex_flush: insert bubble.
  4. hazard: insert bubble; bubble_count += 1 unless it equals all-ones.
  5. otherwise capture: ex_valid = id_valid; all ex_* = id_*. If id_valid = 0, capture as a bubble instead.
- Bubble: ex_valid = 0 and every ex_* field = 0, including datapath fields. Zeroing ex_alu_op gives 00, so ALU control selects ADD. A bubble never writes the register file or memory.
- Control outputs are always gated by ex_valid: no ex_mem_write, ex_reg_write or ex_branch may be 1 while ex_valid = 0.
- rd = x0 never creates a hazard.

## Timing
- Latency: 1 cycle from ID inputs to ex_* outputs.
- load_use_stall is combinational from id_* and registered ex_* state. It has no path from the stage's own next state.
- A load-use stall lasts exactly 1 cycle. After the bubble, the load has left EX, so the same ID instruction is captured on the next edge.
- Back-to-back loads with chained dependence each produce one bubble.
- Reset mid-operation discards the in-flight EX instruction. All outputs read 0 in the cycle after the rst edge.
- bubble_count saturates at 2^CNT_W-1; there is no wrap.

## Test plan
- Reset: assert rst 2 cycles with random id_* inputs -> ex_valid = 0, all ex_* = 0, load_use_stall = 0, bubble_count = 0.
- Capture: id add x3,x1,x2 (alu_op 10, funct3 000, bit_30 0, rs1_data 5, rs2_data 7, reg_write 1) -> next cycle ex_valid 1, ex_alu_op 10, ex_rs1_data 5, ex_rs2_data 7, ex_rd 3.
- Load-use: cycle 0 capture lw x5 (mem_read 1, rd 5); cycle 1 ID add x6,x5,x1 -> load_use_stall 1. Cycle 2: ex_valid 0, bubble_count 1, load_use_stall 0. Cycle 3: ex_rd 6. Repeat with lw x0 then a use of x0 -> no stall, count unchanged.
- Flush vs hazard: same setup as load-use, with ex_flush 1 in cycle 1 -> load_use_stall 0, bubble in cycle 2, bubble_count unchanged.
- ext_stall: hold ext_stall 3 cycles with ex_flush 1 and changing id_* -> ex_* unchanged all 3 cycles. After release with flush still 1 -> bubble.
- Saturation: CNT_W = 2, generate 5 load-use bubbles -> bubble_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush/stall handling and a saturating bubble counter.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [1:0]        id_alu_op,
  input  logic              id_bit_30,
  input  logic [2:0]        id_funct3,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              ex_flush,
  input  logic              ext_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_uses_rs1,
  output logic              ex_uses_rs2,
  output logic [1:0]        ex_alu_op,
  output logic              ex_bit_30,
  output logic [2:0]        ex_funct3,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_count
);
  logic hazard;
  logic bubble;
  assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign load_use_stall = hazard && !ex_flush && !ext_stall;
  assign bubble = ex_flush || hazard || !id_valid;
  // A bubble zeroes every field, so control bits can never be set while ex_valid is low.
  always_ff @(posedge clk) begin
    if (rst || (!ext_stall && bubble)) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_uses_rs1   <= 1'b0;
      ex_uses_rs2   <= 1'b0;
      ex_alu_op     <= '0;
      ex_bit_30     <= 1'b0;
      ex_funct3     <= '0;
      ex_alu_src    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
    end else if (!ext_stall) begin
      ex_valid      <= 1'b1;
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_uses_rs1   <= id_uses_rs1;
      ex_uses_rs2   <= id_uses_rs2;
      ex_alu_op     <= id_alu_op;
      ex_bit_30     <= id_bit_30;
      ex_funct3     <= id_funct3;
      ex_alu_src    <= id_alu_src;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_reg_write  <= id_reg_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_branch     <= id_branch;
    end
  end
  always_ff @(posedge clk) begin
    if (rst)
      bubble_count <= '0;
    else if (load_use_stall && !(&bubble_count))
      bubble_count <= bubble_count + 1'b1;
  end
endmodule
